// File: rtl/hazard_scoreboard.sv
// RAW hazard scoreboard for a 5-stage pipeline: tracks EXE/MEM destinations,
// raises stall/bubble for the ID instruction and counts stall cycles.
module hazard_scoreboard #(
   parameter bit          FORWARD_EN = 1'b0,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [4:0]       id_src1,
   input  logic [4:0]       id_src2,
   input  logic             id_use_src2,
   input  logic             id_wb_en,
   input  logic             id_mem_r_en,
   input  logic [4:0]       id_dest,
   input  logic             flush,
   output logic             stall,
   output logic             bubble,
   output logic [CNT_W-1:0] stall_count
);

   localparam int unsigned REG_W = 5;

   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] dest;
      logic             is_load;
   } slot_t;

   slot_t            exe_q, exe_d, mem_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             exe_match, mem_match, raw_hazard;

   // A slot is a hazard source only when it writes a non-zero register the ID op reads
   function automatic logic slot_match(input slot_t s, input logic [REG_W-1:0] s1,
                                       input logic [REG_W-1:0] s2, input logic use2);
      return s.valid && (s.dest != '0) && ((s.dest == s1) || (use2 && (s.dest == s2)));
   endfunction

   always_comb begin
      exe_match  = slot_match(exe_q, id_src1, id_src2, id_use_src2);
      mem_match  = slot_match(mem_q, id_src1, id_src2, id_use_src2);
      raw_hazard = 1'b0;
      if (FORWARD_EN) begin
         raw_hazard = id_valid && exe_match && exe_q.is_load;
      end else begin
         raw_hazard = id_valid && (exe_match || mem_match);
      end

      // flush overrides the stall but still squashes the ID instruction
      stall  = !rst && raw_hazard && !flush;
      bubble = !rst && (raw_hazard || flush);

      exe_d = bubble ? slot_t'('0) : {id_valid && id_wb_en, id_dest, id_mem_r_en};

      cnt_d = cnt_q;
      if (stall && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         exe_q <= '0;
         mem_q <= '0;
         cnt_q <= '0;
      end else begin
         exe_q <= exe_d;
         mem_q <= exe_q;
         cnt_q <= cnt_d;
      end
   end

   assign stall_count = cnt_q;

endmodule
